// File: rtl/radix4_pkg.sv
// Shared encodings for the radix-4 Booth controller and datapath: state codes,
// load-enable bit indices, mux select codes and the per-state output decode.
package radix4_pkg;

    localparam int ITERS_DEF      = 4;
    localparam int WDOG_SLACK_DEF = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_WAIT_B = 3'd2;
    localparam logic [2:0] S_LOAD_B = 3'd3;
    localparam logic [2:0] S_STEP   = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam int LD_A    = 0;
    localparam int LD_Q    = 1;
    localparam int LD_ACC  = 2;
    localparam int LD_CNT  = 3;
    localparam int LD_DISP = 4;

    localparam int SEL_ACC = 2;
    localparam int SEL_CNT = 3;
    localparam int SEL_Q   = 4;

    localparam logic [1:0] DISP_SW   = 2'b00;
    localparam logic [1:0] DISP_A    = 2'b01;
    localparam logic [1:0] DISP_Q    = 2'b10;
    localparam logic [1:0] DISP_PROD = 2'b11;

    typedef struct packed {
        logic [4:0] ld;
        logic [4:0] sel;
        logic       busy;
        logic       done;
    } ctrl_out_t;

    // Moore decode; ERR and unused codes fall through to all-zero outputs.
    function automatic ctrl_out_t decode_state(input logic [2:0] s);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_IDLE: begin
                o.ld[LD_DISP] = 1'b1;
                o.sel[1:0]    = DISP_SW;
            end
            S_LOAD_A: begin
                o.ld[LD_A] = 1'b1;
            end
            S_WAIT_B: begin
                o.ld[LD_DISP] = 1'b1;
                o.sel[1:0]    = DISP_A;
            end
            S_LOAD_B: begin
                o.ld[LD_Q]   = 1'b1;
                o.ld[LD_ACC] = 1'b1;
                o.ld[LD_CNT] = 1'b1;
                o.busy       = 1'b1;
            end
            S_STEP: begin
                o.ld[LD_Q]     = 1'b1;
                o.ld[LD_ACC]   = 1'b1;
                o.ld[LD_CNT]   = 1'b1;
                o.sel[SEL_ACC] = 1'b1;
                o.sel[SEL_CNT] = 1'b1;
                o.sel[SEL_Q]   = 1'b1;
                o.busy         = 1'b1;
            end
            S_CHECK: begin
                o.sel[SEL_ACC] = 1'b1;
                o.sel[SEL_CNT] = 1'b1;
                o.sel[SEL_Q]   = 1'b1;
                o.busy         = 1'b1;
            end
            S_DONE: begin
                o.ld[LD_DISP] = 1'b1;
                o.sel[1:0]    = DISP_PROD;
                o.done        = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/radix4_go_edge.sv
// Rising-edge detector for the already-synchronised go button; a held button
// produces a single one-cycle go_p.
module radix4_go_edge (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic go_p
);

    logic go_q;

    always_ff @(posedge clk) begin
        if (rst) go_q <= 1'b0;
        else     go_q <= go;
    end

    assign go_p = go & ~go_q;

endmodule

// File: rtl/radix4_ctrl.sv
// Moore controller sequencing the radix-4 Booth multiplier datapath.
// Optional STEP watchdog with ERR state when RADIX4_WDOG_EN is defined.
//
// state  | meaning
// IDLE   | display echoes sw, wait for go (multiplicand)
// LOAD_A | A <= sw
// WAIT_B | display A, wait for go (multiplier)
// LOAD_B | Q <= sw, ACC and CNT cleared
// STEP   | retire one Booth digit
// CHECK  | datapath flag valid; finish or step again
// DONE   | display product, wait for go
// ERR    | watchdog abort, wait for go
module radix4_ctrl
    import radix4_pkg::*;
`ifdef RADIX4_WDOG_EN
#(
    parameter int ITERS      = ITERS_DEF,
    parameter int WDOG_SLACK = WDOG_SLACK_DEF
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       flag,
    output logic [4:0] ld,
    output logic [4:0] sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       go_p;
    ctrl_out_t  outs;

    radix4_go_edge u_go_edge (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .go_p (go_p)
    );

`ifdef RADIX4_WDOG_EN
    localparam logic [2:0] WDOG_LIMIT = 3'(ITERS + WDOG_SLACK);
    logic [2:0] wdog;

    // Counts STEP cycles since LOAD_B; at CHECK it equals the digits attempted.
    always_ff @(posedge clk) begin
        if (rst)                   wdog <= 3'd0;
        else if (state == S_LOAD_B) wdog <= 3'd0;
        else if (state == S_STEP)   wdog <= wdog + 3'd1;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (go_p) state_nxt = S_LOAD_A;
            S_LOAD_A: state_nxt = S_WAIT_B;
            S_WAIT_B: if (go_p) state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_STEP;
            S_STEP:   state_nxt = S_CHECK;
            S_CHECK: begin
                if (flag)                  state_nxt = S_DONE;
`ifdef RADIX4_WDOG_EN
                else if (wdog == WDOG_LIMIT) state_nxt = S_ERR;
`endif
                else                       state_nxt = S_STEP;
            end
            S_DONE:   if (go_p) state_nxt = S_IDLE;
`ifdef RADIX4_WDOG_EN
            S_ERR:    if (go_p) state_nxt = S_IDLE;
`endif
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    assign outs = decode_state(state);
    assign ld   = outs.ld;
    assign sel  = outs.sel;
    assign busy = outs.busy;
    assign done = outs.done;

`ifdef RADIX4_WDOG_EN
    assign err = (state == S_ERR);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_radix4_ctrl.sv
// Self-checking bench for radix4_ctrl: vector table, directed corner sequences
// and a randomized run against an operator-level reference model.
module tb_radix4_ctrl;

    localparam int N_ITERS = 4;

    localparam logic [4:0] LD_IDLE  = 5'b10000;
    localparam logic [4:0] LD_LDA   = 5'b00001;
    localparam logic [4:0] LD_BUSY  = 5'b01110;
    localparam logic [4:0] LD_NONE  = 5'b00000;
    localparam logic [4:0] SEL_SW   = 5'b00000;
    localparam logic [4:0] SEL_A    = 5'b00001;
    localparam logic [4:0] SEL_STEP = 5'b11100;
    localparam logic [4:0] SEL_PROD = 5'b00011;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       flag;
    logic [4:0] ld;
    logic [4:0] sel;
    logic       busy;
    logic       done;
    logic       err;

    logic use_dp;
    logic flag_drv;
    int   dp_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    radix4_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .flag (flag),
        .ld   (ld),
        .sel  (sel),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    // Minimal digit counter standing in for the datapath's registered flag.
    always_ff @(posedge clk) begin
        if (rst)        dp_cnt <= 0;
        else if (ld[3]) dp_cnt <= sel[3] ? dp_cnt + 1 : 0;
    end

    assign flag = use_dp ? (dp_cnt == N_ITERS) : flag_drv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; go = 1'b0; flag_drv = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       go;
        logic       flag;
        logic [4:0] ld;
        logic [4:0] sel;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    typedef struct packed {
        logic [4:0] ld;
        logic [4:0] sel;
        logic       busy;
        logic       done;
    } exp_t;

    // Operator-level view: idle, A captured, waiting for B, running, product shown.
    localparam int M_IDLE = 0, M_LOADA = 1, M_WAITB = 2, M_RUN = 3, M_DONE = 4;

    // In M_RUN, cycle 0 loads the multiplier; odd cycles retire a digit,
    // even cycles after that inspect the datapath flag.
    function automatic exp_t model_out(input int mode, input int i);
        exp_t e;
        e = '{ld: LD_NONE, sel: SEL_SW, busy: 1'b0, done: 1'b0};
        case (mode)
            M_IDLE:  e.ld = LD_IDLE;
            M_LOADA: e.ld = LD_LDA;
            M_WAITB: begin e.ld = LD_IDLE; e.sel = SEL_A; end
            M_RUN: begin
                e.busy = 1'b1;
                if (i == 0)          e.ld = LD_BUSY;
                else if (i % 2 == 1) begin e.ld = LD_BUSY; e.sel = SEL_STEP; end
                else                 e.sel = SEL_STEP;
            end
            M_DONE:  begin e.ld = LD_IDLE; e.sel = SEL_PROD; e.done = 1'b1; end
            default: e = e;
        endcase
        return e;
    endfunction

    vec_t tbl[16];

    initial begin
        int   lat, steps, n_la, m_mode, m_i;
        logic seen, got_err, m_goq, gop;
        exp_t e;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, LD_IDLE, SEL_SW,   1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, LD_IDLE, SEL_SW,   1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, LD_IDLE, SEL_SW,   1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, LD_LDA,  SEL_SW,   1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, LD_IDLE, SEL_A,    1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, LD_IDLE, SEL_A,    1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, LD_IDLE, SEL_A,    1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, LD_BUSY, SEL_SW,   1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, LD_BUSY, SEL_STEP, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, LD_NONE, SEL_STEP, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, LD_BUSY, SEL_STEP, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, LD_NONE, SEL_STEP, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, LD_IDLE, SEL_PROD, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, LD_IDLE, SEL_PROD, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, LD_IDLE, SEL_SW,   1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, LD_IDLE, SEL_SW,   1'b0, 1'b0, 1'b0};

        use_dp = 1'b0; flag_drv = 1'b0; rst = 1'b1; go = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; go = tbl[i].go; flag_drv = tbl[i].flag;
            tick();
            chk($sformatf("vec%0d.ld", i),   ld,   tbl[i].ld);
            chk($sformatf("vec%0d.sel", i),  sel,  tbl[i].sel);
            chk($sformatf("vec%0d.busy", i), busy, tbl[i].busy);
            chk($sformatf("vec%0d.done", i), done, tbl[i].done);
            chk($sformatf("vec%0d.err", i),  err,  tbl[i].err);
        end

        // Happy path with the datapath counter supplying flag.
        use_dp = 1'b1;
        do_reset();
        pulse_go();
        tick();
        chk("happy.wait_b_sel", sel, SEL_A);
        go = 1'b1; lat = 0; steps = 0;
        while (!done && lat < 40) begin
            tick();
            go = 1'b0;
            lat++;
            if (ld == LD_BUSY && sel == SEL_STEP) steps++;
        end
        chk("happy.latency", lat, 10);
        chk("happy.steps", steps, N_ITERS);
        chk("happy.done_sel", sel, SEL_PROD);
        chk("happy.done_ld", ld, LD_IDLE);
        chk("happy.done_busy", busy, 1'b0);
        tick();
        chk("happy.done_hold", done, 1'b1);

        // Held button: one LOAD_A only, then park in WAIT_B.
        do_reset();
        go = 1'b1; n_la = 0;
        repeat (20) begin
            tick();
            if (ld == LD_LDA) n_la++;
        end
        go = 1'b0;
        chk("held.load_a_count", n_la, 1);
        chk("held.wait_b_sel", sel, SEL_A);
        chk("held.wait_b_ld", ld, LD_IDLE);

        // Reset during the second STEP.
        do_reset();
        pulse_go();
        tick();
        go = 1'b1; steps = 0; lat = 0;
        while (steps < 2 && lat < 20) begin
            tick();
            go = 1'b0;
            lat++;
            if (ld == LD_BUSY && sel == SEL_STEP) steps++;
        end
        chk("midrst.reached_step2", steps, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.ld", ld, LD_IDLE);
        chk("midrst.sel", sel, SEL_SW);
        chk("midrst.busy", busy, 1'b0);
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("midrst.no_done", seen, 1'b0);
        chk("midrst.idle_busy", busy, 1'b0);

        // flag stuck low.
        use_dp = 1'b0;
        do_reset();
        pulse_go();
        tick();
        go = 1'b1; steps = 0; got_err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            go = 1'b0;
            if (ld == LD_BUSY && sel == SEL_STEP) steps++;
            if (err) begin
                got_err = 1'b1;
                break;
            end
        end
`ifdef RADIX4_WDOG_EN
        chk("wdog.err_seen", got_err, 1'b1);
        chk("wdog.steps", steps, 6);
        chk("wdog.err_ld", ld, LD_NONE);
        chk("wdog.err_sel", sel, SEL_SW);
        chk("wdog.err_busy", busy, 1'b0);
        pulse_go();
        chk("wdog.exit_ld", ld, LD_IDLE);
        chk("wdog.exit_err", err, 1'b0);
`else
        chk("nowdog.err_seen", got_err, 1'b0);
        chk("nowdog.still_busy", busy, 1'b1);
        chk("nowdog.keeps_stepping", steps > 6, 1'b1);
`endif

        // Randomized run against the operator-level model.
        do_reset();
        m_mode = M_IDLE; m_i = 0; m_goq = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) go = ~go;
            if (m_mode == M_RUN && m_i > 0 && m_i % 2 == 0)
                flag_drv = (m_i / 2 >= N_ITERS) ? 1'b1 : ($urandom_range(0, 5) == 0);
            else
                flag_drv = $urandom_range(0, 1);

            if (rst) begin
                m_mode = M_IDLE; m_i = 0; m_goq = 1'b0;
            end else begin
                gop   = go & ~m_goq;
                m_goq = go;
                case (m_mode)
                    M_IDLE:  if (gop) m_mode = M_LOADA;
                    M_LOADA: m_mode = M_WAITB;
                    M_WAITB: if (gop) begin m_mode = M_RUN; m_i = 0; end
                    M_RUN: begin
                        if (m_i > 0 && m_i % 2 == 0 && flag_drv) m_mode = M_DONE;
                        else                                     m_i++;
                    end
                    M_DONE:  if (gop) m_mode = M_IDLE;
                    default: m_mode = M_IDLE;
                endcase
            end

            tick();
            e = model_out(m_mode, m_i);
            chk($sformatf("rand%0d.ld", c),   ld,   e.ld);
            chk($sformatf("rand%0d.sel", c),  sel,  e.sel);
            chk($sformatf("rand%0d.busy", c), busy, e.busy);
            chk($sformatf("rand%0d.done", c), done, e.done);
            chk($sformatf("rand%0d.err", c),  err,  1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
